// File: rtl/reg_writeback_pkg.sv
// Shared types and constants for the register-file write-back slice.
package reg_writeback_pkg;
    localparam int BITS      = 8;
    localparam int RBITS     = 3;
    localparam int NREGS     = 2 ** RBITS;
    localparam int LDQ_DEPTH = 2;
    localparam logic [RBITS-1:0] REG_ZERO = {RBITS{1'b0}};

    typedef logic [RBITS-1:0] ridx_t;
    typedef logic [BITS-1:0]  data_t;
    typedef logic [NREGS-1:0] mask_t;

    typedef struct packed {
        logic  valid;
        ridx_t rd;
    } ldq_entry_t;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_LOAD = 2'd1,
        WB_ALU  = 2'd2
    } wb_src_e;

    // One-hot register mask; x0 never contributes since it is hardwired zero.
    function automatic mask_t reg_bit(input ridx_t r);
        mask_t m;
        m = {NREGS{1'b0}};
        if (r != REG_ZERO) begin
            m[r] = 1'b1;
        end else begin
            m = {NREGS{1'b0}};
        end
        return m;
    endfunction
endpackage

// File: rtl/reg_writeback_if.sv
// Producer-side handshake bundle (ALU results, load issue/return) for reg_writeback.
interface reg_writeback_if;
    import reg_writeback_pkg::*;

    logic  alu_valid;
    ridx_t alu_rd;
    data_t alu_data;
    logic  alu_ready;
    logic  ld_issue;
    ridx_t ld_issue_rd;
    logic  ld_valid;
    data_t ld_data;
    logic  ld_full;

    modport master (
        output alu_valid, alu_rd, alu_data, ld_issue, ld_issue_rd, ld_valid, ld_data,
        input  alu_ready, ld_full
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_issue, ld_issue_rd, ld_valid, ld_data,
        output alu_ready, ld_full
    );
endinterface

// File: rtl/reg_writeback_wb_ldq.sv
// Two-entry in-order FIFO of outstanding load destinations; entry 0 is always the head.
module wb_ldq
    import reg_writeback_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_run,
    input  logic                        i_push,
    input  ridx_t                       i_push_rd,
    input  logic                        i_pop,
    output ridx_t                       o_head_rd,
    output logic                        o_full,
    output logic                        o_empty,
    output logic                        o_ovf,
    output logic                        o_unf,
    output ldq_entry_t [LDQ_DEPTH-1:0]  o_entries
);
    ldq_entry_t [LDQ_DEPTH-1:0] r_q;
    ldq_entry_t [LDQ_DEPTH-1:0] w_q_nxt;
    logic                       w_pop_ok;

    // Next queue contents: pop shifts the tail forward before any push lands.
    always_comb begin
        w_pop_ok = i_pop && r_q[0].valid;
        o_unf    = i_pop && !r_q[0].valid;
        o_ovf    = 1'b0;
        w_q_nxt  = r_q;
        if (w_pop_ok) begin
            w_q_nxt[0] = r_q[1];
            w_q_nxt[1] = {1'b0, REG_ZERO};
        end else begin
            w_q_nxt = r_q;
        end
        if (i_push) begin
            if (!w_q_nxt[0].valid) begin
                w_q_nxt[0] = {1'b1, i_push_rd};
            end else if (!w_q_nxt[1].valid) begin
                w_q_nxt[1] = {1'b1, i_push_rd};
            end else begin
                o_ovf = 1'b1;
            end
        end else begin
            o_ovf = 1'b0;
        end
    end

    // Queue storage, frozen while run is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= {LDQ_DEPTH{1'b0, REG_ZERO}};
        end else if (i_run) begin
            r_q <= w_q_nxt;
        end else begin
            r_q <= r_q;
        end
    end

    // Status view derived straight from storage.
    always_comb begin
        o_head_rd = r_q[0].rd;
        o_empty   = !r_q[0].valid;
        o_full    = r_q[1].valid;
        o_entries = r_q;
    end
endmodule

// File: rtl/reg_writeback.sv
// Register-file write port driver: arbitrates load returns over ALU results, exports busy scoreboard.
// Optional REG_WB_BYPASS_EN adds same-cycle forwarding ports and drops the output-stage busy term.
module reg_writeback
    import reg_writeback_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_run,
    reg_writeback_if.slave      wb,
    output mask_t               o_busy_mask,
    output logic                o_we,
    output ridx_t               o_rd,
    output data_t               o_rd_din,
`ifdef REG_WB_BYPASS_EN
    output logic                o_byp_valid,
    output ridx_t               o_byp_rd,
    output data_t               o_byp_data,
`endif
    output logic                o_err
);
    ldq_entry_t [LDQ_DEPTH-1:0] w_entries;
    ridx_t   w_head_rd;
    logic    w_full, w_empty, w_ovf, w_unf;
    logic    w_ld_wr, w_alu_ok;
    mask_t   w_busy;
    wb_src_e w_src;
    logic    r_we, r_err;
    ridx_t   r_rd;
    data_t   r_din;

    wb_ldq u_ldq (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_run     (i_run),
        .i_push    (wb.ld_issue),
        .i_push_rd (wb.ld_issue_rd),
        .i_pop     (wb.ld_valid),
        .o_head_rd (w_head_rd),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_ovf     (w_ovf),
        .o_unf     (w_unf),
        .o_entries (w_entries)
    );

    // Busy scoreboard from queued loads plus, without bypass, the write in flight.
    always_comb begin
        w_busy = {NREGS{1'b0}};
        for (int i = 0; i < LDQ_DEPTH; i++) begin
            if (w_entries[i].valid) begin
                w_busy = w_busy | reg_bit(w_entries[i].rd);
            end else begin
                w_busy = w_busy;
            end
        end
`ifndef REG_WB_BYPASS_EN
        if (r_we) begin
            w_busy = w_busy | reg_bit(r_rd);
        end else begin
            w_busy = w_busy;
        end
`endif
    end

    // Write-port arbitration; the ALU also waits on a same-cycle issue to its destination (WAW).
    always_comb begin
        w_ld_wr  = i_run && wb.ld_valid && !w_empty;
        w_alu_ok = i_run && wb.alu_valid && !wb.ld_valid && !w_busy[wb.alu_rd]
                   && !(wb.ld_issue && (wb.ld_issue_rd == wb.alu_rd));
        if (w_ld_wr) begin
            w_src = WB_LOAD;
        end else if (w_alu_ok) begin
            w_src = WB_ALU;
        end else begin
            w_src = WB_NONE;
        end
    end

    // Registered write stage; x0 destinations are consumed without raising we.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we  <= 1'b0;
            r_rd  <= REG_ZERO;
            r_din <= {BITS{1'b0}};
        end else if (!i_run) begin
            r_we  <= 1'b0;
        end else begin
            case (w_src)
                WB_LOAD: begin
                    r_we  <= (w_head_rd != REG_ZERO);
                    r_rd  <= w_head_rd;
                    r_din <= wb.ld_data;
                end
                WB_ALU: begin
                    r_we  <= (wb.alu_rd != REG_ZERO);
                    r_rd  <= wb.alu_rd;
                    r_din <= wb.alu_data;
                end
                default: begin
                    r_we  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky protocol error: queue overflow or return with nothing outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (i_run && (w_ovf || w_unf)) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

    // Output drive.
    always_comb begin
        wb.alu_ready = w_alu_ok;
        wb.ld_full   = w_full;
        o_busy_mask  = w_busy;
        o_we         = r_we;
        o_rd         = r_rd;
        o_rd_din     = r_din;
        o_err        = r_err;
`ifdef REG_WB_BYPASS_EN
        o_byp_valid  = r_we;
        o_byp_rd     = r_rd;
        o_byp_data   = r_din;
`endif
    end
endmodule

// File: tb/tb_reg_writeback.sv
// Scoreboard bench for reg_writeback: directed scenarios followed by randomized traffic.
module tb_reg_writeback;
    import reg_writeback_pkg::*;

    typedef struct {
        int rd;
        int data;
        int cyc;
    } wr_t;

    logic  clk, rst_n, run;
    mask_t busy_mask;
    logic  we, err;
    ridx_t rd;
    data_t rd_din;
`ifdef REG_WB_BYPASS_EN
    logic  byp_valid;
    ridx_t byp_rd;
    data_t byp_data;
`endif

    reg_writeback_if bus ();

    reg_writeback dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_run       (run),
        .wb          (bus),
        .o_busy_mask (busy_mask),
        .o_we        (we),
        .o_rd        (rd),
        .o_rd_din    (rd_din),
`ifdef REG_WB_BYPASS_EN
        .o_byp_valid (byp_valid),
        .o_byp_rd    (byp_rd),
        .o_byp_data  (byp_data),
`endif
        .o_err       (err)
    );

    int  n_chk = 0;
    int  n_pass = 0;
    int  cyc = 0;
    wr_t exp_q[$];
    int  pend[$];
    bit  m_err = 1'b0;
    bit  last_we = 1'b0;
    int  last_rd = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    endtask

    // Reference: a register is busy while any outstanding load targets it or it was written last cycle.
    function automatic logic [7:0] model_busy();
        logic [7:0] b;
        b = 8'h00;
        foreach (pend[i]) if (pend[i] != 0) b[pend[i]] = 1'b1;
`ifndef REG_WB_BYPASS_EN
        if (last_we) b[last_rd] = 1'b1;
`endif
        return b;
    endfunction

    task automatic clear_inputs();
        run = 1'b0;
        bus.alu_valid = 1'b0; bus.alu_rd = 3'd0; bus.alu_data = 8'h00;
        bus.ld_issue = 1'b0; bus.ld_issue_rd = 3'd0; bus.ld_valid = 1'b0; bus.ld_data = 8'h00;
    endtask

    task automatic model_reset();
        pend.delete();
        exp_q.delete();
        m_err = 1'b0;
        last_we = 1'b0;
        last_rd = 0;
    endtask

    // One clock of stimulus: drive, check combinational outputs, advance the reference.
    task automatic step(input bit rn, input bit av, input int ard, input int ad,
                        input bit iss, input int ird, input bit ldv, input int ldd,
                        output bit rdy);
        logic [7:0] bsy;
        bit wr;
        int wrd, wd;
        @(negedge clk);
        run = rn;
        bus.alu_valid = av; bus.alu_rd = 3'(ard); bus.alu_data = 8'(ad);
        bus.ld_issue = iss; bus.ld_issue_rd = 3'(ird);
        bus.ld_valid = ldv; bus.ld_data = 8'(ldd);
        #1;
        bsy = model_busy();
        rdy = rn && av && !ldv && !bsy[ard] && !(iss && ird == ard);
        chk("alu_ready", {31'd0, bus.alu_ready}, {31'd0, rdy});
        chk("busy_mask", {24'd0, busy_mask}, {24'd0, bsy});
        chk("ld_full", {31'd0, bus.ld_full}, {31'd0, pend.size() == 2});
        chk("err", {31'd0, err}, {31'd0, m_err});
        if (rn) begin
            wr = 1'b0; wrd = 0; wd = 0;
            if (ldv) begin
                if (pend.size() > 0) begin
                    wrd = pend.pop_front(); wd = ldd; wr = 1'b1;
                end else m_err = 1'b1;
            end else if (rdy) begin
                wrd = ard; wd = ad; wr = 1'b1;
            end
            if (iss) begin
                if (pend.size() < 2) pend.push_back(ird);
                else m_err = 1'b1;
            end
            last_we = wr && (wrd != 0);
            last_rd = wrd;
            if (last_we) exp_q.push_back('{wrd, wd & 255, cyc + 1});
        end else begin
            last_we = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every write the DUT presents must match the oldest expected write, in the expected cycle.
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rst_n) begin
                if (we) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write_rd", {29'd0, rd}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_rd", {29'd0, rd}, e.rd);
                        chk("wr_data", {24'd0, rd_din}, e.data);
                        chk("wr_cycle", cyc, e.cyc);
                    end
                end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    e = exp_q.pop_front();
                    chk("missing_write_we", {31'd0, we}, 32'd1);
                end
            end
        end
    end

    initial begin
        bit r;
        bit a_v;
        int a_rd, a_d;
        rst_n = 1'b0;
        clear_inputs();
        #1;
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_rd", {29'd0, rd}, 32'd0);
        chk("rst_rd_din", {24'd0, rd_din}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_busy", {24'd0, busy_mask}, 32'd0);
        chk("rst_full", {31'd0, bus.ld_full}, 32'd0);
        do_reset();

        // Plain ALU write, then load/ALU WAW stall, collision and x0 handling.
        step(1, 1, 2, 8'h5A, 0, 0, 0, 0, r);
        chk("alu_accept_now", {31'd0, r}, 32'd1);
        step(1, 0, 0, 0, 1, 4, 0, 0, r);
        step(1, 1, 4, 8'h77, 0, 0, 0, 0, r);
        step(1, 1, 4, 8'h77, 0, 0, 1, 8'h11, r);
        step(1, 1, 4, 8'h77, 0, 0, 0, 0, r);
        step(1, 1, 4, 8'h77, 0, 0, 0, 0, r);
        step(1, 0, 0, 0, 1, 1, 0, 0, r);
        step(1, 1, 5, 8'h33, 0, 0, 1, 8'h22, r);
        step(1, 1, 5, 8'h33, 0, 0, 0, 0, r);
        step(1, 1, 0, 8'hEE, 0, 0, 0, 0, r);
        step(1, 0, 0, 0, 1, 0, 0, 0, r);
        step(1, 0, 0, 0, 0, 0, 1, 8'h44, r);

        // Overflow: third issue without a pop is dropped; queue drains 6 then 7.
        step(1, 0, 0, 0, 1, 6, 0, 0, r);
        step(1, 0, 0, 0, 1, 7, 0, 0, r);
        step(1, 0, 0, 0, 1, 3, 0, 0, r);
        step(1, 0, 0, 0, 0, 0, 1, 8'hA6, r);
        chk("ovf_err", {31'd0, err}, 32'd1);
        step(1, 0, 0, 0, 0, 0, 1, 8'hA7, r);
        step(1, 0, 0, 0, 0, 0, 0, 0, r);

        // Asynchronous reset while a write to r3 is on the port.
        do_reset();
        step(1, 1, 3, 8'h99, 0, 0, 0, 0, r);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_we", {31'd0, we}, 32'd0);
        chk("midrst_rd_din", {24'd0, rd_din}, 32'd0);
        chk("midrst_busy", {24'd0, busy_mask}, 32'd0);
        do_reset();

        // Underflow on an empty queue.
        step(1, 0, 0, 0, 0, 0, 1, 8'h55, r);
        step(1, 0, 0, 0, 0, 0, 0, 0, r);
        chk("unf_err", {31'd0, err}, 32'd1);
        do_reset();

        // Randomized traffic; the ALU holds its request until accepted.
        a_v = 1'b0; a_rd = 0; a_d = 0;
        for (int i = 0; i < 600; i++) begin
            bit rn, iss, ldv;
            int ird;
            if (!a_v && $urandom_range(0, 9) < 6) begin
                a_v = 1'b1; a_rd = $urandom_range(0, 7); a_d = $urandom_range(0, 255);
            end
            rn  = ($urandom_range(0, 9) != 0);
            iss = ($urandom_range(0, 9) < 3);
            ird = $urandom_range(0, 7);
            ldv = (pend.size() > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 99) < 2);
            step(rn, a_v, a_rd, a_d, iss, ird, ldv, $urandom_range(0, 255), r);
            if (r) a_v = 1'b0;
        end
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, r);
        chk("writes_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
Write-side driver for the 8-register CPU register file. It accepts results from the ALU and from the load unit, and tracks outstanding load destinations in a 2-entry in-order queue. It arbitrates the single write port and drives a registered we/rd/rd_din to the register file. It exports a busy scoreboard so decode can stall on read-after-write hazards against pending loads.

Parameters:
BITS, 8, datapath width
RBITS, 3, register index width (8 registers, x0 hardwired zero)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
run  in  1  global advance enable; 0 freezes all state
alu_valid  in  1  ALU result present
alu_rd  in  RBITS  ALU destination
alu_data  in  BITS  ALU result
alu_ready  out  1  ALU result accepted this cycle
ld_issue  in  1  load issued to memory; capture destination
ld_issue_rd  in  RBITS  load destination
ld_valid  in  1  load data returning (in issue order)
ld_data  in  BITS  returned load data
ld_full  out  1  load queue holds 2 entries
busy_mask  out  2**RBITS  bit r set = register r has a pending write (bit 0 always 0)
we  out  1  register file write enable (registered)
rd  out  RBITS  register file write index (registered)
rd_din  out  BITS  register file write data (registered)
err  out  1  sticky protocol error

Behaviour:
- Reset (rst_n low, asynchronous): queue empty, we=0, rd=0, rd_din=0, err=0, alu_ready=0, busy_mask=0, ld_full=0.
- run=0: no state changes; we is forced 0 on the next edge; alu_ready=0.
- Load queue: 2-entry FIFO of destination indices plus valid bits.
  - ld_issue pushes ld_issue_rd.
  - ld_valid pops the head; the head index is paired with ld_data.
  - Pop and push in the same cycle are legal when full (pop first).
  - Push when full without a pop: dropped, err set.
  - ld_valid when empty: ignored, err set.
- Write-port arbitration, once per cycle with run=1:
  - A load return has priority and is registered into we/rd/rd_din at the next edge.
  - An ALU result is accepted (alu_ready=1) only when all three hold: no ld_valid this cycle, alu_rd is not busy, and alu_rd is not ld_issue_rd of a same-cycle ld_issue. The last two conditions form the WAW stall.
  - alu_ready is combinational. The ALU must hold alu_valid/alu_rd/alu_data stable until it sees alu_ready.
- Latency: accepted result to we asserted is exactly 1 cycle. we is a one-cycle pulse per write.
- x0: a write with destination 0 is accepted and consumed but produces we=0. A load to x0 still occupies a queue entry to preserve ordering and never sets a busy bit.
- busy_mask (combinational): bit r is the OR over two sources:
  - a valid queue entry with rd==r;
  - the output stage holding we=1, rd=r. This covers the write-in-flight cycle.
- Two queued loads to the same register: the bit stays set until both have returned and been written.
- err is sticky and cleared only by reset.

Optional Feature:
- Macro: REG_WB_BYPASS_EN.
- When defined: extra outputs byp_valid (1), byp_rd (RBITS) and byp_data (BITS) mirror we/rd/rd_din combinationally, so decode can forward a value written in the same cycle it is read. busy_mask then excludes the output-stage term.
- When undefined: the bypass ports are absent and busy_mask includes the output-stage term, per the busy_mask rule above.

Decomposition:
- Shared package: BITS, RBITS, NREGS=2**RBITS, REG_ZERO=0, LDQ_DEPTH=2.
- Sub-module wb_ldq: a 2-entry destination FIFO providing push, pop, head index, full, empty and a per-entry valid/index view for scoreboard generation.

Test Plan:
- Reset mid-write: we=1 rd=3 pending, rst_n=0 -> we=0, rd_din=0 and busy_mask=0 immediately, without waiting for a clock edge.
- ALU write alu_rd=2, alu_data=0x5A -> alu_ready=1 the same cycle; we=1, rd=2, rd_din=0x5A one cycle later.
- ld_issue rd=4, then ALU to rd=4 -> alu_ready=0 while busy_mask[4]=1; ld_valid with data 0x11 -> write of 0x11 to r4, then the ALU write proceeds the cycle after busy_mask[4] clears.
- Collision: ld_valid (head rd=1, data 0x22) and alu_valid rd=5 in the same cycle -> r1=0x22 written first; ALU accepted the next cycle.
- Overflow and underflow:
  - Two issues (ld_full=1), then a third issue with no pop -> err=1, queue contents unchanged.
  - A separate run with ld_valid on an empty queue -> err=1.
- x0 handling: ALU rd=0 -> alu_ready=1, we stays 0. Load to rd=0 -> queue occupied, busy_mask stays 0.
